reg_scoreboard: RTL

Issue-side register scoreboard for the dual-lane execute pipeline. It records the destination register of every instruction that issues. It counts down the cycles until each result becomes forwardable on the EXE bypass network, and tracks long-latency producers (load, div) until their writeback. Issue is stalled per lane whenever a source operand cannot yet be supplied by the forward unit or the register file. It sits between decode/issue and the register-read stage, and produces the same en/rd information that the bypass network consumes.

---
 rtl/reg_scoreboard_pkg.sv | 25 ++
 rtl/reg_scoreboard_sb_entry.sv | 49 ++++
 rtl/reg_scoreboard.sv | 87 ++++++++
 3 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared pipeline constants for the issue-side register scoreboard:
// register/counter widths and the latency encoding used by the issue lanes.
package reg_scoreboard_pkg;

  localparam int REG_W = 5;
  localparam int CNT_W = 3;

  localparam logic [CNT_W-1:0] LAT_LONG = 3'd7;
  localparam logic [CNT_W-1:0] LAT_ALU  = 3'd1;
  localparam logic [CNT_W-1:0] LAT_MUL  = 3'd2;
  localparam logic [CNT_W-1:0] LAT_LOAD = 3'd0;
  localparam logic [CNT_W-1:0] LAT_DIV  = 3'd0;

  // A lat-L producer is forwardable L-1 cycles from now; lat 0 means wait for writeback.
  function automatic logic [CNT_W-1:0] lat_to_cnt(input logic [CNT_W-1:0] lat);
    logic [CNT_W-1:0] v;
    if (lat == 3'd0) begin
      v = LAT_LONG;
    end else begin
      v = lat - 3'd1;
    end
    return v;
  endfunction

endpackage

// File: rtl/reg_scoreboard_sb_entry.sv
// One architectural register's countdown: 0 ready, 1..6 cycles left,
// 7 waiting for a long-latency writeback.
module sb_entry
  import reg_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_flush,
  input  logic             i_set1,
  input  logic [CNT_W-1:0] i_val1,
  input  logic             i_set0,
  input  logic [CNT_W-1:0] i_val0,
  input  logic             i_wb,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Priority: flush, younger lane 1, lane 0, writeback, countdown.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_flush) begin
      w_cnt_nxt = 3'd0;
    end else if (i_set1) begin
      w_cnt_nxt = i_val1;
    end else if (i_set0) begin
      w_cnt_nxt = i_val0;
    end else if (r_cnt == LAT_LONG) begin
      w_cnt_nxt = i_wb ? 3'd0 : LAT_LONG;
    end else if (r_cnt != 3'd0) begin
      w_cnt_nxt = r_cnt - 3'd1;
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= 3'd0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/reg_scoreboard.sv
// Dual-lane issue scoreboard: per-register countdowns, in-order per-lane
// stall generation and the busy vector consumed by the bypass network.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             issue0_valid,
  input  logic [REG_W-1:0] issue0_rj,
  input  logic [REG_W-1:0] issue0_rk,
  input  logic             issue0_we,
  input  logic [REG_W-1:0] issue0_rd,
  input  logic [CNT_W-1:0] issue0_lat,
  input  logic             issue1_valid,
  input  logic [REG_W-1:0] issue1_rj,
  input  logic [REG_W-1:0] issue1_rk,
  input  logic             issue1_we,
  input  logic [REG_W-1:0] issue1_rd,
  input  logic [CNT_W-1:0] issue1_lat,
  input  logic             wb0_valid,
  input  logic [REG_W-1:0] wb0_rd,
  input  logic             wb1_valid,
  input  logic [REG_W-1:0] wb1_rd,
  output logic             stall0,
  output logic             stall1,
  output logic [NREG-1:0]  busy_vec
);

  logic [CNT_W-1:0] w_cnt [NREG];
  logic [NREG-1:0]  w_busy;
  logic             w_stall0;
  logic             w_stall1;
  logic             w_fire0;
  logic             w_fire1;
  logic [CNT_W-1:0] w_val0;
  logic [CNT_W-1:0] w_val1;

  assign w_cnt[0]  = 3'd0;
  assign w_busy[0] = 1'b0;

  // r0 never busy, so indexing w_busy by a zero source never stalls.
  always_comb begin
    w_stall0 = 1'b0;
    w_stall1 = 1'b0;
    if (issue0_valid) begin
      w_stall0 = w_busy[issue0_rj] | w_busy[issue0_rk];
    end else begin
      w_stall0 = 1'b0;
    end
    if (issue1_valid) begin
      w_stall1 = w_stall0 | w_busy[issue1_rj] | w_busy[issue1_rk] |
                 (issue0_valid & issue0_we & (issue0_rd != 5'd0) &
                  ((issue1_rj == issue0_rd) | (issue1_rk == issue0_rd)));
    end else begin
      w_stall1 = 1'b0;
    end
  end

  assign w_fire0 = issue0_valid & ~w_stall0 & issue0_we;
  assign w_fire1 = issue1_valid & ~w_stall1 & issue1_we;
  assign w_val0  = lat_to_cnt(issue0_lat);
  assign w_val1  = lat_to_cnt(issue1_lat);

  for (genvar g = 1; g < NREG; g++) begin : g_entry
    sb_entry u_entry (
      .clk     (clk),
      .rstn    (rstn),
      .i_flush (flush),
      .i_set1  (w_fire1 & (issue1_rd == REG_W'(g))),
      .i_val1  (w_val1),
      .i_set0  (w_fire0 & (issue0_rd == REG_W'(g))),
      .i_val0  (w_val0),
      .i_wb    ((wb0_valid & (wb0_rd == REG_W'(g))) |
                (wb1_valid & (wb1_rd == REG_W'(g)))),
      .o_cnt   (w_cnt[g])
    );
    assign w_busy[g] = |w_cnt[g];
  end

  assign stall0   = w_stall0;
  assign stall1   = w_stall1;
  assign busy_vec = w_busy;

endmodule
